// File: rtl/snn_stoch_pkg.sv
// Shared definitions for stochastic-stream readback blocks: FSM encoding and
// the saturating ones-count to fraction scaler.
package snn_stoch_pkg;

    localparam int ND_DEF = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } stoch_state_e;

    // A full window of ones would need one more bit than the output holds, so it
    // clamps to all-ones instead of wrapping to zero.
    function automatic logic [31:0] sat_scale(input logic [31:0] ones,
                                              input int          win_log2,
                                              input int          nd);
        logic [31:0] full;
        full = 32'd1 << win_log2;
        if (ones >= full)
            sat_scale = (32'd1 << nd) - 32'd1;
        else
            sat_scale = ones >> (win_log2 - nd);
    endfunction

endpackage

// File: rtl/stch_ones_counter.sv
// EN-qualified window sample counter plus ones accumulator; flags the last
// sample of each 2^WIN_LOG2 window and exposes the count including that sample.
module stch_ones_counter #(
    parameter int WIN_LOG2 = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clr_i,
    input  logic                en_i,
    input  logic                s_i,
    output logic [WIN_LOG2:0]   ones_sum_o,
    output logic                last_o
);

    localparam logic [WIN_LOG2-1:0] CNT_MAX = '1;

    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [WIN_LOG2:0]   ones_q, ones_d;

    assign last_o     = en_i && (cnt_q == CNT_MAX);
    assign ones_sum_o = ones_q + (WIN_LOG2+1)'(en_i & s_i);

    // Clearing on the last sample lets the next window start on the very next cycle.
    always_comb begin
        cnt_d  = cnt_q;
        ones_d = ones_q;
        if (clr_i || last_o) begin
            cnt_d  = '0;
            ones_d = '0;
        end else if (en_i) begin
            cnt_d  = cnt_q + WIN_LOG2'(1);
            ones_d = ones_sum_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            ones_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            ones_q <= ones_d;
        end
    end

endmodule

// File: rtl/stch2dec_counter.sv
// Stochastic-to-decimal converter: counts ones over a window of enabled samples
// and reports the fraction ones/2^WIN_LOG2 scaled to ND bits.
module stch2dec_counter
    import snn_stoch_pkg::*;
#(
    parameter int ND       = ND_DEF,
    parameter int WIN_LOG2 = 8,
    parameter int CONT     = 0
) (
    input  logic          CLK,
    input  logic          INIT,
    input  logic          START,
    input  logic          EN,
    input  logic          S,
    output logic [ND-1:0] D,
    output logic          VALID,
    output logic          BUSY
);

    if (WIN_LOG2 < ND || WIN_LOG2 < 1 || ND < 1) begin : g_bad_params
        $error("stch2dec_counter: need 1 <= ND <= WIN_LOG2");
    end

    stoch_state_e        state_q, state_d;
    logic [ND-1:0]       d_q, d_d;
    logic                valid_q, valid_d;
    logic                cnt_en, cnt_clr, last;
    logic [WIN_LOG2:0]   ones_sum;

    assign cnt_en  = EN && (state_q == ST_ACCUM);
    assign cnt_clr = (state_q == ST_IDLE);

    stch_ones_counter #(
        .WIN_LOG2 (WIN_LOG2)
    ) u_cnt (
        .clk_i      (CLK),
        .rst_i      (INIT),
        .clr_i      (cnt_clr),
        .en_i       (cnt_en),
        .s_i        (S),
        .ones_sum_o (ones_sum),
        .last_o     (last)
    );

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (last) begin
                    valid_d = 1'b1;
                    d_d     = ND'(sat_scale(32'(ones_sum), WIN_LOG2, ND));
                    if (CONT == 0) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (INIT) begin
            state_q <= ST_IDLE;
            d_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            valid_q <= valid_d;
        end
    end

    assign D     = d_q;
    assign VALID = valid_q;
    assign BUSY  = (state_q == ST_ACCUM);

endmodule
